// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencing for IF/ID, ID/EXE, EXE/MEM; optional perf counters via PIPE_HAZARD_CTRL_PERF_EN
module pipe_hazard_ctrl #(
  parameter int RF_ADDR_W  = 5,
  parameter int PERF_CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [RF_ADDR_W-1:0] id_rs1,
  input  logic                 id_rs1_ren,
  input  logic [RF_ADDR_W-1:0] id_rs2,
  input  logic                 id_rs2_ren,
  input  logic                 exe_valid,
  input  logic [RF_ADDR_W-1:0] exe_rd,
  input  logic                 exe_is_load,
  input  logic                 exe_redirect,
  input  logic                 exe_mdu_op,
  input  logic                 mdu_done,
  input  logic                 mem_req,
  input  logic                 mem_ack,
  output logic                 pc_stall,
  output logic                 if_id_stall,
  output logic                 id_exe_stall,
  output logic                 exe_mem_stall,
  output logic                 if_id_flush,
  output logic                 id_exe_flush,
  output logic                 exe_mem_flush,
  output logic                 mdu_start,
  output logic [1:0]           ctrl_state
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] perf_stall_cnt,
  output logic [PERF_CNT_W-1:0] perf_flush_cnt
`endif
);
  typedef enum logic [1:0] {RUN = 2'd0, MDU_WAIT = 2'd1, MEM_WAIT = 2'd2} state_t;
  state_t state, state_nxt;
  logic [7:0] ctl;
  logic load_use;
  if (PERF_CNT_W < 1) begin : g_bad_perf_w
    $error("PERF_CNT_W must be at least 1");
  end
  assign load_use = exe_valid & exe_is_load & (exe_rd != '0) & id_valid &
                    ((id_rs1_ren & (id_rs1 == exe_rd)) | (id_rs2_ren & (id_rs2 == exe_rd)));
  // ctl = {pc, if_id, id_exe, exe_mem stalls, if_id, id_exe, exe_mem flushes, mdu_start}
  always_comb begin
    ctl = '0;
    state_nxt = RUN;
    case (state)
      RUN: begin
        if (mem_req & !mem_ack) begin
          ctl = 8'b1111_000_0;
          state_nxt = MEM_WAIT;
        end else if (exe_valid & exe_mdu_op) begin
          ctl = 8'b1110_001_1;
          state_nxt = MDU_WAIT;
        end else if (exe_valid & exe_redirect) begin
          ctl = 8'b0000_110_0;
        end else if (load_use) begin
          ctl = 8'b1100_010_0;
        end
      end
      MDU_WAIT: begin
        ctl = mdu_done ? 8'b0000_000_0 : 8'b1110_001_0;
        state_nxt = mdu_done ? RUN : MDU_WAIT;
      end
      MEM_WAIT: begin
        ctl = mem_ack ? 8'b0000_000_0 : 8'b1111_000_0;
        state_nxt = mem_ack ? RUN : MEM_WAIT;
      end
      default: state_nxt = RUN;
    endcase
  end
  assign {pc_stall, if_id_stall, id_exe_stall, exe_mem_stall,
          if_id_flush, id_exe_flush, exe_mem_flush, mdu_start} = rst ? 8'b0000_111_0 : ctl;
  assign ctrl_state = state;
  // state register; reset abandons any pending MDU or memory wait
  always_ff @(posedge clk) begin
    state <= rst ? RUN : state_nxt;
  end
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  // saturating counts of stalled and flushing cycles
  always_ff @(posedge clk) begin
    perf_stall_cnt <= rst ? '0 : (pc_stall & ~&perf_stall_cnt) ? perf_stall_cnt + 1'b1 : perf_stall_cnt;
    perf_flush_cnt <= rst ? '0 :
                      ((if_id_flush | id_exe_flush | exe_mem_flush) & ~&perf_flush_cnt) ? perf_flush_cnt + 1'b1 : perf_flush_cnt;
  end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic id_valid = 1'b0, id_rs1_ren = 1'b0, id_rs2_ren = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, exe_rd = '0;
  logic exe_valid = 1'b0, exe_is_load = 1'b0, exe_redirect = 1'b0, exe_mdu_op = 1'b0;
  logic mdu_done = 1'b0, mem_req = 1'b0, mem_ack = 1'b0;
  logic pc_stall, if_id_stall, id_exe_stall, exe_mem_stall;
  logic if_id_flush, id_exe_flush, exe_mem_flush, mdu_start;
  logic [1:0] ctrl_state;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif
  int checks = 0, passed = 0;
  logic [9:0] exp_q[$], obs_q[$];
  logic [9:0] e, o;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs1_ren(id_rs1_ren),
    .id_rs2(id_rs2), .id_rs2_ren(id_rs2_ren),
    .exe_valid(exe_valid), .exe_rd(exe_rd), .exe_is_load(exe_is_load),
    .exe_redirect(exe_redirect), .exe_mdu_op(exe_mdu_op), .mdu_done(mdu_done),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_exe_stall(id_exe_stall),
    .exe_mem_stall(exe_mem_stall), .if_id_flush(if_id_flush), .id_exe_flush(id_exe_flush),
    .exe_mem_flush(exe_mem_flush), .mdu_start(mdu_start), .ctrl_state(ctrl_state)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // f = {rst, id_valid, rs1_ren, rs2_ren, exe_valid, is_load, redirect, mdu_op, mdu_done, mem_req, mem_ack}
  // ex = {state[1:0], pc/if_id/id_exe/exe_mem stall, if_id/id_exe/exe_mem flush, mdu_start}
  task automatic step(input logic [10:0] f, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic [9:0] ex);
    @(negedge clk);
    {rst, id_valid, id_rs1_ren, id_rs2_ren, exe_valid, exe_is_load, exe_redirect,
     exe_mdu_op, mdu_done, mem_req, mem_ack} = f;
    id_rs1 = rs1;
    id_rs2 = rs2;
    exe_rd = rd;
    exp_q.push_back(ex);
    #2;
    obs_q.push_back({ctrl_state, pc_stall, if_id_stall, id_exe_stall, exe_mem_stall,
                     if_id_flush, id_exe_flush, exe_mem_flush, mdu_start});
  endtask

  task automatic test_reset;
    step(11'b1_0_0_0_0_0_0_0_0_0_0, 5'd0, 5'd0, 5'd0, 10'b00_0000_111_0);
    step(11'b1_1_0_1_1_1_0_1_0_1_0, 5'd0, 5'd5, 5'd5, 10'b00_0000_111_0);
    step(11'b0_0_0_0_0_0_0_0_0_0_0, 5'd0, 5'd0, 5'd0, 10'b00_0000_000_0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) $display("FAIL reset step%0d got=%b exp=%b", i, o, e); else passed++;
    end
  endtask

  task automatic test_load_use;
    step(11'b0_1_0_1_1_1_0_0_0_0_0, 5'd0, 5'd5, 5'd5, 10'b00_1100_010_0);
    step(11'b0_0_0_0_0_0_0_0_0_0_0, 5'd0, 5'd0, 5'd0, 10'b00_0000_000_0);
    step(11'b0_1_0_1_1_1_0_0_0_0_0, 5'd0, 5'd0, 5'd0, 10'b00_0000_000_0);
    step(11'b0_1_1_0_1_1_0_0_0_0_0, 5'd7, 5'd0, 5'd7, 10'b00_1100_010_0);
    step(11'b0_1_0_0_1_1_0_0_0_0_0, 5'd7, 5'd7, 5'd7, 10'b00_0000_000_0);
    step(11'b0_0_1_1_1_1_0_0_0_0_0, 5'd7, 5'd7, 5'd7, 10'b00_0000_000_0);
    step(11'b0_1_1_1_1_0_0_0_0_0_0, 5'd7, 5'd7, 5'd7, 10'b00_0000_000_0);
    step(11'b0_1_1_1_0_1_0_0_0_0_0, 5'd7, 5'd7, 5'd7, 10'b00_0000_000_0);
    step(11'b0_1_1_1_1_1_0_0_0_0_0, 5'd3, 5'd9, 5'd9, 10'b00_1100_010_0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) $display("FAIL load_use step%0d got=%b exp=%b", i, o, e); else passed++;
    end
  endtask

  task automatic test_redirect;
    step(11'b0_1_0_1_1_1_1_0_0_0_0, 5'd0, 5'd5, 5'd5, 10'b00_0000_110_0);
    step(11'b0_0_0_0_1_0_1_0_0_0_0, 5'd0, 5'd0, 5'd0, 10'b00_0000_110_0);
    step(11'b0_0_0_0_0_0_1_0_0_0_0, 5'd0, 5'd0, 5'd0, 10'b00_0000_000_0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) $display("FAIL redirect step%0d got=%b exp=%b", i, o, e); else passed++;
    end
  endtask

  task automatic test_mdu;
    step(11'b0_0_0_0_1_0_0_1_0_0_0, 5'd0, 5'd0, 5'd0, 10'b00_1110_001_1);
    for (int c = 1; c <= 3; c++)
      step(11'b0_0_0_0_1_0_0_1_0_0_0, 5'd0, 5'd0, 5'd0, 10'b01_1110_001_0);
    step(11'b0_0_0_0_1_0_0_1_1_0_0, 5'd0, 5'd0, 5'd0, 10'b01_0000_000_0);
    step(11'b0_0_0_0_0_0_0_0_0_0_0, 5'd0, 5'd0, 5'd0, 10'b00_0000_000_0);
    step(11'b0_0_0_0_0_0_0_0_1_0_0, 5'd0, 5'd0, 5'd0, 10'b00_0000_000_0);
    step(11'b0_0_0_0_1_0_1_1_0_0_0, 5'd0, 5'd0, 5'd0, 10'b00_1110_001_1);
    step(11'b0_0_0_0_1_0_0_1_0_1_0, 5'd0, 5'd0, 5'd0, 10'b01_1110_001_0);
    step(11'b0_0_0_0_0_0_0_0_1_0_0, 5'd0, 5'd0, 5'd0, 10'b01_0000_000_0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) $display("FAIL mdu step%0d got=%b exp=%b", i, o, e); else passed++;
    end
  endtask

  task automatic test_mem_wait;
    step(11'b0_0_0_0_0_0_0_0_0_1_0, 5'd0, 5'd0, 5'd0, 10'b00_1111_000_0);
    step(11'b0_0_0_0_0_0_0_0_0_0_0, 5'd0, 5'd0, 5'd0, 10'b10_1111_000_0);
    step(11'b0_0_0_0_0_0_0_0_0_0_0, 5'd0, 5'd0, 5'd0, 10'b10_1111_000_0);
    step(11'b0_0_0_0_0_0_0_0_0_0_1, 5'd0, 5'd0, 5'd0, 10'b10_0000_000_0);
    step(11'b0_0_0_0_0_0_0_0_0_0_0, 5'd0, 5'd0, 5'd0, 10'b00_0000_000_0);
    step(11'b0_0_0_0_0_0_0_0_0_1_1, 5'd0, 5'd0, 5'd0, 10'b00_0000_000_0);
    step(11'b0_1_0_1_1_1_0_0_0_1_0, 5'd0, 5'd4, 5'd4, 10'b00_1111_000_0);
    step(11'b0_1_0_1_1_1_1_0_0_0_1, 5'd0, 5'd4, 5'd4, 10'b10_0000_000_0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) $display("FAIL mem_wait step%0d got=%b exp=%b", i, o, e); else passed++;
    end
  endtask

  task automatic test_collision_reset;
    step(11'b0_0_0_0_1_0_0_1_0_1_0, 5'd0, 5'd0, 5'd0, 10'b00_1111_000_0);
    step(11'b0_0_0_0_1_0_0_1_0_0_1, 5'd0, 5'd0, 5'd0, 10'b10_0000_000_0);
    step(11'b0_0_0_0_1_0_0_1_0_0_0, 5'd0, 5'd0, 5'd0, 10'b00_1110_001_1);
    step(11'b0_0_0_0_1_0_0_1_0_0_0, 5'd0, 5'd0, 5'd0, 10'b01_1110_001_0);
    step(11'b1_0_0_0_1_0_0_1_0_0_0, 5'd0, 5'd0, 5'd0, 10'b01_0000_111_0);
    step(11'b0_0_0_0_0_0_0_0_1_0_0, 5'd0, 5'd0, 5'd0, 10'b00_0000_000_0);
    step(11'b0_0_0_0_0_0_0_0_0_0_0, 5'd0, 5'd0, 5'd0, 10'b00_0000_000_0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) $display("FAIL collision_reset step%0d got=%b exp=%b", i, o, e); else passed++;
    end
  endtask

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  task automatic test_perf;
    step(11'b1_0_0_0_0_0_0_0_0_0_0, 5'd0, 5'd0, 5'd0, 10'b00_0000_111_0);
    step(11'b0_0_0_0_0_0_0_0_0_1_0, 5'd0, 5'd0, 5'd0, 10'b00_1111_000_0);
    step(11'b0_0_0_0_0_0_0_0_0_0_0, 5'd0, 5'd0, 5'd0, 10'b10_1111_000_0);
    step(11'b0_0_0_0_0_0_0_0_0_0_0, 5'd0, 5'd0, 5'd0, 10'b10_1111_000_0);
    step(11'b0_0_0_0_0_0_0_0_0_0_1, 5'd0, 5'd0, 5'd0, 10'b10_0000_000_0);
    step(11'b0_1_0_1_1_1_0_0_0_0_0, 5'd0, 5'd5, 5'd5, 10'b00_1100_010_0);
    step(11'b0_0_0_0_0_0_0_0_0_0_0, 5'd0, 5'd0, 5'd0, 10'b00_0000_000_0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) $display("FAIL perf step%0d got=%b exp=%b", i, o, e); else passed++;
    end
    checks++;
    if (perf_stall_cnt !== 32'd4) $display("FAIL perf_stall_cnt got=%0d exp=4", perf_stall_cnt); else passed++;
    checks++;
    if (perf_flush_cnt !== 32'd1) $display("FAIL perf_flush_cnt got=%0d exp=1", perf_flush_cnt); else passed++;
  endtask
`endif

  initial begin
    test_reset;
    test_load_use;
    test_redirect;
    test_mdu;
    test_mem_wait;
    test_collision_reset;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    test_perf;
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
